// File: rtl/regfile_pkg.sv
// Shared sizing constants for the register file: data width, register count,
// read-select width and the index of the hardwired zero register.
package regfile_pkg;

    localparam int unsigned REG_W    = 32;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned SEL_W    = 5;
    localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/reg_en.sv
// Single register with synchronous active-high reset and a write enable.
module reg_en #(
    parameter int unsigned W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Reset wins over a write presented in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile_bank.sv
// Register-file storage: 31 physical registers plus a hardwired zero register,
// written by a one-hot vector, read through two combinational ports with
// optional same-cycle write bypass. Malformed (multi-hot) vectors are dropped
// and latched into a sticky error flag.
module regfile_bank #(
    parameter int unsigned REG_W    = regfile_pkg::REG_W,
    parameter int unsigned NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int unsigned SEL_W    = regfile_pkg::SEL_W,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                clock,
    input  logic                ctrl_reset,
    input  logic [NUM_REGS-1:0] write_onehot,
    input  logic [REG_W-1:0]    data_writeReg,
    input  logic [SEL_W-1:0]    ctrl_readRegA,
    input  logic [SEL_W-1:0]    ctrl_readRegB,
    output logic [REG_W-1:0]    data_readRegA,
    output logic [REG_W-1:0]    data_readRegB,
    output logic                err_multi_hot
);

    import regfile_pkg::*;

    localparam logic [SEL_W-1:0]    ZeroSel = SEL_W'(ZERO_REG);
    localparam logic [NUM_REGS-1:0] OneVec  = NUM_REGS'(1);

    logic [REG_W-1:0]    regs [NUM_REGS];
    logic                multi_hot;
    logic                bypass_ok;
    logic [NUM_REGS-1:0] reg_we;
    logic                err_q;

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign multi_hot = |(write_onehot & (write_onehot - OneVec));
    assign reg_we    = multi_hot ? '0 : write_onehot;
    assign bypass_ok = BYPASS && !ctrl_reset && !multi_hot;

    assign regs[ZERO_REG] = '0;

    for (genvar k = 1; k < NUM_REGS; k++) begin : g_regs
        reg_en #(
            .W(REG_W)
        ) u_reg (
            .clock(clock),
            .reset(ctrl_reset),
            .en   (reg_we[k]),
            .d    (data_writeReg),
            .q    (regs[k])
        );
    end

    // Sticky error flag: set by any multi-hot vector, cleared only by reset.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            err_q <= 1'b0;
        end else if (multi_hot) begin
            err_q <= 1'b1;
        end
    end

    assign err_multi_hot = err_q;

    // Read muxes with bypass of the register currently being written.
    always_comb begin
        data_readRegA = regs[ctrl_readRegA];
        data_readRegB = regs[ctrl_readRegB];
        if (bypass_ok && write_onehot[ctrl_readRegA] && ctrl_readRegA != ZeroSel) begin
            data_readRegA = data_writeReg;
        end
        if (bypass_ok && write_onehot[ctrl_readRegB] && ctrl_readRegB != ZeroSel) begin
            data_readRegB = data_writeReg;
        end
    end

endmodule

// File: doc/regfile_bank.md
Name: regfile_bank

Overview:
- Storage stage of the register file; sits directly downstream of the write-port decoder.
- Consumes the decoder's 32-bit one-hot, enable-gated write vector plus write data, and holds 32 x 32-bit registers.
- Register 0 is hardwired to zero.
- Provides two asynchronous read ports with same-cycle write bypass, and a sticky error flag that fires when the write vector is not one-hot.

Parameters:
- REG_W, 32, data width of each register.
- NUM_REGS, 32, number of registers; equals the write-vector width.
- SEL_W, 5, read-select width, log2(NUM_REGS).
- BYPASS, 1, when 1 a read of the register being written returns the write data in the same cycle; when 0 it returns the stored (old) value.

Ports:
- clock, input, 1, single clock; all state updates on the rising edge.
- ctrl_reset, input, 1, synchronous, active-high reset.
- write_onehot, input, NUM_REGS, per-register write enables from the write-port decoder (already gated by ctrl_writeEnable).
- data_writeReg, input, REG_W, write data.
- ctrl_readRegA, input, SEL_W, read-port A select.
- ctrl_readRegB, input, SEL_W, read-port B select.
- data_readRegA, output, REG_W, read-port A data (combinational).
- data_readRegB, output, REG_W, read-port B data (combinational).
- err_multi_hot, output, 1, sticky flag: a write vector with two or more bits set was presented.

Behaviour:
- Reset: at a rising edge with ctrl_reset=1, all registers clear to 0 and err_multi_hot clears to 0. Any write presented in that cycle is discarded.
- Write, valid vector: at a rising edge with ctrl_reset=0 and exactly one bit k set (k != 0), reg[k] <= data_writeReg. Write latency is 1 cycle: the new value is stored from the following cycle.
- Write to register 0: bit 0 set alone is accepted as a legal vector but has no effect. reg[0] always reads 0 and is not a physical flop.
- Zero vector: no register changes (idle or write disabled).
- Multi-hot vector (two or more bits set, bit 0 counted):
  - No register is written in that cycle.
  - err_multi_hot <= 1 at that edge and stays 1 until the next reset edge.
  - Subsequent legal writes proceed normally.
- Reads: data_readRegX = reg[ctrl_readRegX], combinational, zero cycles of latency. Select 0 always yields 0.
- Bypass (BYPASS=1): if ctrl_reset=0, the vector is legal one-hot, write_onehot[ctrl_readRegX]=1 and ctrl_readRegX != 0, then data_readRegX = data_writeReg in the same cycle.
  - Bypass is suppressed while ctrl_reset=1 and for multi-hot vectors; the stored value is returned in those cases.
- Simultaneous events:
  - Both read ports may address the same register, or the register being written; each port resolves independently.
  - Reset has priority over write.
- Reset asserted mid-sequence: reads before the reset edge return stored contents. From the cycle after the edge all reads return 0.
- No X propagation: every register holds a defined value after the first reset. Output values before the first reset are unspecified.

Decomposition:
- Package regfile_pkg: REG_W, NUM_REGS, SEL_W and the zero-register index constant, shared with the write-port decoder and read-port logic.
- Sub-module reg_en: one REG_W-bit register with synchronous active-high reset and write enable. It is instantiated NUM_REGS-1 times via generate (index 1..NUM_REGS-1).
- One-hot check (popcount > 1), bypass compare and the 32:1 read muxes live in regfile_bank.

Test Plan:
1. Reset, then read all 32 selects on both ports -> every read = 0x00000000, err_multi_hot=0.
2. write_onehot=0x00000008, data=0xDEADBEEF, one edge, then vector 0 -> ctrl_readRegA=3 returns 0xDEADBEEF from the next cycle; all other registers still 0.
3. write_onehot=0x00000001, data=0xFFFFFFFF -> reg 0 still reads 0; err_multi_hot stays 0.
4. BYPASS=1: write_onehot=0x00000020 (reg 5), data=0x12345678, ctrl_readRegB=5 in the same cycle -> data_readRegB=0x12345678 before the edge. With BYPASS=0 -> old value 0 until the edge.
5. write_onehot=0x00000006, data=0xAAAA5555 -> regs 1 and 2 unchanged, err_multi_hot=1 after the edge. A later legal write to reg 1 succeeds; the flag remains 1 until ctrl_reset.
6. Regs 7=0x11, 9=0x22 loaded. Assert ctrl_reset together with write_onehot=0x00000080, data=0x99 -> read of 7 that cycle returns 0x11 (no bypass). After the edge, regs 7 and 9 read 0 and err_multi_hot=0.
